// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if
//  Write-side bus of the memory UART-programming port.
//  master : driven by the loader (uart_mem_loader)
//  slave  : consumed by the RAM mux / CPU side
//  upg_wen_o   one-cycle word write strobe
//  upg_sel_o   target RAM: 0 = instruction, 1 = data
//  upg_adr_o   word address
//  upg_dat_o   write data
//  upg_done_o  programming finished, sticky until reset
//  upg_err_o   one-cycle error pulse
interface uart_mem_loader_if #(
    parameter int ADDR_W = 14
);
    logic              upg_wen_o;
    logic              upg_sel_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              upg_err_o;

    modport master (
        output upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );

    modport slave (
        input upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//  Receives an 8N1 byte stream, frames it into segments
//  (header, 16-bit word count, little-endian 32-bit words) and issues word
//  writes to instruction or data RAM. A 0xFF header ends programming.
//  upg_clk_i   in   UPG clock, all logic on rising edge
//  upg_rstn_i  in   asynchronous active-low reset
//  rx_i        in   UART serial input, idle high, asynchronous
//  upg         master modport of uart_mem_loader_if (write bus, done, err)
//
//  state   | meaning
//  R_IDLE  | waiting for a falling edge on the synchronised line
//  R_START | half-bit wait, confirm start bit still low
//  R_DATA  | sampling 8 data bits mid-bit, LSB first
//  R_STOP  | sampling stop bit; 1 -> byte valid, 0 -> framing error
//  F_HDR   | expecting segment header (00 instr, 01 data, FF end)
//  F_LEN0  | expecting word count low byte
//  F_LEN1  | expecting word count high byte
//  F_DATA  | collecting words, one write per 4 bytes
//  F_DONE  | programming finished, input ignored until reset
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic                      upg_clk_i,
    input  logic                      upg_rstn_i,
    input  logic                      rx_i,
    uart_mem_loader_if.master         upg
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {F_HDR, F_LEN0, F_LEN1, F_DATA, F_DONE} fr_state_t;

    // ---------------- receiver ----------------
    logic             rx_m, rx_s, rx_d;
    rx_state_t        r_q, r_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       bit_q, bit_nxt;
    logic [7:0]       sh_q, sh_nxt;
    logic             bv_q, bv_nxt;
    logic             rx_err;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
            r_q   <= R_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
            bv_q  <= 1'b0;
        end else begin
            rx_m  <= rx_i;
            rx_s  <= rx_m;
            rx_d  <= rx_s;
            r_q   <= r_nxt;
            cnt_q <= cnt_nxt;
            bit_q <= bit_nxt;
            sh_q  <= sh_nxt;
            bv_q  <= bv_nxt;
        end
    end

    always_comb begin
        r_nxt   = r_q;
        cnt_nxt = cnt_q;
        bit_nxt = bit_q;
        sh_nxt  = sh_q;
        bv_nxt  = 1'b0;
        rx_err  = 1'b0;
        case (r_q)
            // Edge (not level) detect: after a bad stop bit the line may still
            // be low, and we must wait for it to return high first.
            R_IDLE: begin
                if (rx_d && !rx_s) begin
                    r_nxt   = R_START;
                    cnt_nxt = HALF_LOAD;
                end
            end
            R_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        r_nxt   = R_DATA;
                        cnt_nxt = BIT_LOAD;
                        bit_nxt = 3'd0;
                    end else begin
                        r_nxt = R_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            R_DATA: begin
                if (cnt_q == '0) begin
                    sh_nxt  = {rx_s, sh_q[7:1]};
                    cnt_nxt = BIT_LOAD;
                    if (bit_q == 3'd7) begin
                        r_nxt = R_STOP;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            R_STOP: begin
                if (cnt_q == '0) begin
                    r_nxt = R_IDLE;
                    if (rx_s) begin
                        bv_nxt = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // ---------------- framer ----------------
    fr_state_t         f_q, f_nxt;
    logic              sel_q, sel_nxt;
    logic [15:0]       len_q, len_nxt;
    logic [15:0]       idx_q, idx_nxt;
    logic [1:0]        bcnt_q, bcnt_nxt;
    logic [23:0]       word_q, word_nxt;
    logic [TO_W-1:0]   to_q, to_nxt;
    logic              wen_q, wen_nxt;
    logic              osel_q, osel_nxt;
    logic [ADDR_W-1:0] adr_q, adr_nxt;
    logic [31:0]       dat_q, dat_nxt;
    logic              err_q;
    logic              fr_err;
    logic              timed, timeout;
    fr_state_t         f_eff;

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            f_q    <= F_HDR;
            sel_q  <= 1'b0;
            len_q  <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            to_q   <= TO_LOAD;
            wen_q  <= 1'b0;
            osel_q <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            f_q    <= f_nxt;
            sel_q  <= sel_nxt;
            len_q  <= len_nxt;
            idx_q  <= idx_nxt;
            bcnt_q <= bcnt_nxt;
            word_q <= word_nxt;
            to_q   <= to_nxt;
            wen_q  <= wen_nxt;
            osel_q <= osel_nxt;
            adr_q  <= adr_nxt;
            dat_q  <= dat_nxt;
            err_q  <= rx_err | fr_err;
        end
    end

    assign timed   = (f_q == F_LEN0) || (f_q == F_LEN1) || (f_q == F_DATA);
    assign timeout = timed && (to_q == '0);
    // A byte arriving on the timeout cycle is treated as a fresh header.
    assign f_eff   = timeout ? F_HDR : f_q;

    always_comb begin
        f_nxt    = f_q;
        sel_nxt  = sel_q;
        len_nxt  = len_q;
        idx_nxt  = idx_q;
        bcnt_nxt = bcnt_q;
        word_nxt = word_q;
        to_nxt   = TO_LOAD;
        wen_nxt  = 1'b0;
        osel_nxt = osel_q;
        adr_nxt  = adr_q;
        dat_nxt  = dat_q;
        fr_err   = 1'b0;

        if (timed && !timeout && !bv_q) begin
            to_nxt = to_q - TO_W'(1);
        end
        if (timeout) begin
            fr_err   = 1'b1;
            f_nxt    = F_HDR;
            bcnt_nxt = 2'd0;
        end

        if (bv_q) begin
            case (f_eff)
                F_HDR: begin
                    case (sh_q)
                        8'h00: begin sel_nxt = 1'b0; f_nxt = F_LEN0; end
                        8'h01: begin sel_nxt = 1'b1; f_nxt = F_LEN0; end
                        8'hFF: f_nxt = F_DONE;
                        default: fr_err = 1'b1;
                    endcase
                end
                F_LEN0: begin
                    len_nxt = {8'h00, sh_q};
                    f_nxt   = F_LEN1;
                end
                F_LEN1: begin
                    len_nxt = {sh_q, len_q[7:0]};
                    if ({sh_q, len_q[7:0]} == 16'h0000) begin
                        f_nxt = F_HDR;
                    end else begin
                        f_nxt    = F_DATA;
                        idx_nxt  = '0;
                        bcnt_nxt = 2'd0;
                    end
                end
                F_DATA: begin
                    case (bcnt_q)
                        2'd0: word_nxt[7:0]   = sh_q;
                        2'd1: word_nxt[15:8]  = sh_q;
                        2'd2: word_nxt[23:16] = sh_q;
                        default: begin
                            wen_nxt  = 1'b1;
                            adr_nxt  = idx_q[ADDR_W-1:0];
                            dat_nxt  = {sh_q, word_q};
                            osel_nxt = sel_q;
                            idx_nxt  = idx_q + 16'd1;
                            if (idx_q == len_q - 16'd1) begin
                                f_nxt = F_HDR;
                            end
                        end
                    endcase
                    bcnt_nxt = bcnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_sel_o  = osel_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;
    assign upg.upg_done_o = (f_q == F_DONE);
    assign upg.upg_err_o  = err_q;
endmodule
